// File: rtl/arb_mux_pkg.sv
// Shared types and helpers for the arb_mux registered channel multiplexer.
package arb_mux_pkg;

  // Channel selection policy, sampled every cycle.
  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_RR     = 1'b1
  } mode_t;

  // Increment a channel index, wrapping at n rather than at a power of two.
  function automatic int next_idx(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/arb_mux_rr_pick.sv
// Round-robin pick: first requesting channel at or after ptr, wrapping modulo N.
module rr_pick #(
  parameter  int N    = 16,
  localparam int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic            gnt_valid,
  output logic [SELW-1:0] gnt
);

  localparam logic [SELW:0] N_EXT = (SELW + 1)'(N);

  logic [2*N-1:0] req2;
  logic [N-1:0]   rot;
  logic [SELW-1:0] off;
  logic [SELW:0]  sum;

  // Rotate a doubled copy so ptr lands at bit 0, find the lowest set bit, then
  // map the offset back to an absolute channel index.
  always_comb begin
    // NOTE: every output of an always_comb gets a value before any branch, so no latch can be inferred.
    off       = '0;
    gnt       = '0;
    req2      = {req, req};
    rot       = N'(req2 >> ptr);
    gnt_valid = |req;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = SELW'(i);
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= N_EXT) gnt = SELW'(sum - N_EXT);
    else              gnt = sum[SELW-1:0];
  end

endmodule

// File: rtl/arb_mux.sv
// N-channel registered multiplexer with valid/ready on every port; selects by
// index (direct) or by a rotating round-robin pointer.
module arb_mux
  import arb_mux_pkg::*;
#(
  parameter  int WIDTH = 64,
  parameter  int N     = 16,
  localparam int SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  mode_t              mode,
  input  logic [SELW-1:0]    sel,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_src,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int            NPAD  = 2 ** SELW;
  localparam logic [SELW:0] N_EXT = (SELW + 1)'(N);

  logic [SELW-1:0]  ptr;
  logic             rr_valid;
  logic [SELW-1:0]  rr_gnt;
  logic [NPAD-1:0]  valid_pad;
  logic             sel_ok;
  logic             grant_valid;
  logic [SELW-1:0]  grant;
  logic             slot_free;
  logic             xfer;
  logic [WIDTH-1:0] sel_data;

  rr_pick #(.N(N)) u_rr_pick (
    .req       (in_valid),
    .ptr       (ptr),
    .gnt_valid (rr_valid),
    .gnt       (rr_gnt)
  );

  // Grant selection and ready generation; ready never looks at in_data.
  always_comb begin
    valid_pad          = '0;
    valid_pad[N-1:0]   = in_valid;
    sel_ok             = ({1'b0, sel} < N_EXT);
    slot_free          = !out_valid || out_ready;
    if (mode == MODE_RR) begin
      grant       = rr_gnt;
      grant_valid = rr_valid;
    end else begin
      grant       = sel;
      grant_valid = sel_ok && valid_pad[sel];
    end
    xfer     = slot_free && grant_valid;
    in_ready = '0;
    if (xfer) in_ready[grant] = 1'b1;
  end

  // Data path mux for the granted channel.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant == SELW'(i)) sel_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  // Output slot and round-robin pointer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      ptr       <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (xfer) begin
        out_data  <= sel_data;
        out_src   <= grant;
        out_valid <= 1'b1;
        if (mode == MODE_RR) ptr <= SELW'(next_idx(int'(grant), N));
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_arb_mux.sv
// Directed-vector bench for arb_mux: a 16x64 instance and a 6x8 instance.
module tb_arb_mux;
  import arb_mux_pkg::*;

  logic clk;
  logic reset_n;

  // 16-channel, 64-bit instance
  logic [63:0]     words [16];
  logic [16*64-1:0] in_data;
  logic [15:0]     in_valid;
  logic [15:0]     in_ready;
  mode_t           mode;
  logic [3:0]      sel;
  logic [63:0]     out_data;
  logic [3:0]      out_src;
  logic            out_valid;
  logic            out_ready;

  // 6-channel, 8-bit instance
  logic [7:0]      s_words [6];
  logic [6*8-1:0]  s_in_data;
  logic [5:0]      s_in_valid;
  logic [5:0]      s_in_ready;
  mode_t           s_mode;
  logic [2:0]      s_sel;
  logic [7:0]      s_out_data;
  logic [2:0]      s_out_src;
  logic            s_out_valid;
  logic            s_out_ready;

  int n_checks = 0;
  int n_pass   = 0;

  arb_mux #(.WIDTH(64), .N(16)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  arb_mux #(.WIDTH(8), .N(6)) dut6 (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_data   (s_in_data),
    .in_valid  (s_in_valid),
    .in_ready  (s_in_ready),
    .mode      (s_mode),
    .sel       (s_sel),
    .out_data  (s_out_data),
    .out_src   (s_out_src),
    .out_valid (s_out_valid),
    .out_ready (s_out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 16; i++) in_data[i*64 +: 64] = words[i];
    for (int i = 0; i < 6; i++)  s_in_data[i*8 +: 8] = s_words[i];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) words[i] = 64'h1111_0000_0000_0000 + 64'(i);
    for (int i = 0; i < 6; i++)  s_words[i] = 8'hA0 + 8'(i);
    reset_n     = 1'b0;
    in_valid    = '0;
    mode        = MODE_DIRECT;
    sel         = '0;
    out_ready   = 1'b0;
    s_in_valid  = '0;
    s_mode      = MODE_DIRECT;
    s_sel       = '0;
    s_out_ready = 1'b0;
    #12 reset_n = 1'b1;

    // 1. load a word, then async reset drops it immediately
    sel = 4'd5; in_valid = 16'h0020;
    tick();
    check("pre_reset_valid", 64'(out_valid), 64'd1);
    reset_n = 1'b0;
    #1;
    check("reset_valid", 64'(out_valid), 64'd0);
    check("reset_data", out_data, 64'd0);
    check("reset_src", 64'(out_src), 64'd0);
    #2 reset_n = 1'b1;
    words[5] = 64'hDEAD_BEEF; out_ready = 1'b1;
    #1;
    check("direct_ready", 64'(in_ready), 64'h0020);
    tick();
    check("direct_valid", 64'(out_valid), 64'd1);
    check("direct_data", out_data, 64'hDEAD_BEEF);
    check("direct_src", 64'(out_src), 64'd5);

    // 2. round robin over all-valid: 0..15 then wrap to 0..3
    mode = MODE_RR; in_valid = 16'hFFFF;
    for (int k = 0; k < 20; k++) begin
      tick();
      check($sformatf("rr_src_%0d", k), 64'(out_src), 64'(k % 16));
      check($sformatf("rr_data_%0d", k), out_data, words[k % 16]);
    end

    // 3. sparse RR: serve 13, then 0,3,0 with wrap past 14/15 and no idle cycle
    in_valid = 16'h2000;
    tick();
    check("sparse_src13", 64'(out_src), 64'd13);
    in_valid = 16'h0009;
    tick();
    check("sparse_src0", 64'(out_src), 64'd0);
    tick();
    check("sparse_src3", 64'(out_src), 64'd3);
    check("sparse_valid", 64'(out_valid), 64'd1);
    tick();
    check("sparse_src0b", 64'(out_src), 64'd0);

    // 4. backpressure holds the slot; release gives same-cycle ready
    in_valid = 16'h0004; out_ready = 1'b0;
    #1;
    check("stall_ready0", 64'(in_ready), 64'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("stall_ready_%0d", k), 64'(in_ready), 64'd0);
      check($sformatf("stall_src_%0d", k), 64'(out_src), 64'd0);
      check($sformatf("stall_data_%0d", k), out_data, words[0]);
      check($sformatf("stall_valid_%0d", k), 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    #1;
    check("release_ready", 64'(in_ready), 64'h0004);
    tick();
    check("release_src", 64'(out_src), 64'd2);
    words[2] = 64'h0123_4567_89AB_CDEF;
    check("b2b_ready", 64'(in_ready), 64'h0004);
    tick();
    check("b2b_valid", 64'(out_valid), 64'd1);
    check("b2b_data", out_data, 64'h0123_4567_89AB_CDEF);

    // 6. direct transfers leave ptr at 3; RR resumes from 3
    mode = MODE_DIRECT; sel = 4'd9; in_valid = 16'h0200;
    #1;
    check("sw_direct_ready", 64'(in_ready), 64'h0200);
    tick();
    check("sw_direct_src1", 64'(out_src), 64'd9);
    tick();
    check("sw_direct_src2", 64'(out_src), 64'd9);
    mode = MODE_RR; in_valid = 16'hFFFF;
    #1;
    check("sw_rr_ready", 64'(in_ready), 64'h0008);
    tick();
    check("sw_rr_src", 64'(out_src), 64'd3);
    // selected channel not valid: no grant, slot drains, src holds
    mode = MODE_DIRECT; sel = 4'd9; in_valid = 16'h0100;
    #1;
    check("nogrant_ready", 64'(in_ready), 64'd0);
    tick();
    check("drain_valid", 64'(out_valid), 64'd0);
    check("drain_src", 64'(out_src), 64'd3);
    check("drain_data", out_data, words[3]);

    // 5. N=6: sel>=N never grants; RR wraps 5 -> 0
    s_mode = MODE_DIRECT; s_sel = 3'd7; s_in_valid = 6'h3F; s_out_ready = 1'b1;
    #1;
    check("n6_sel7_ready", 64'(s_in_ready), 64'd0);
    tick();
    check("n6_sel7_valid", 64'(s_out_valid), 64'd0);
    s_mode = MODE_RR; s_in_valid = 6'h10;
    tick();
    check("n6_src4", 64'(s_out_src), 64'd4);
    s_in_valid = 6'h3F;
    #1;
    check("n6_ready5", 64'(s_in_ready), 64'h20);
    tick();
    check("n6_src5", 64'(s_out_src), 64'd5);
    check("n6_data5", 64'(s_out_data), 64'(s_words[5]));
    check("n6_ready0", 64'(s_in_ready), 64'h01);
    tick();
    check("n6_src0", 64'(s_out_src), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
